ssd_display_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display between N_REQ requesters (e.g. counter, switch echo, status codes).
- Each requester presents a full digit frame. The arbiter grants one requester at a time, round-robin, with a minimum hold time so each owner's value stays readable.
- Drives the `digits` array of sev_seg_controller directly; sits between the user datapaths and the display controller.

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/ssd_rr_picker.sv | 36 +++
 rtl/ssd_display_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ssd_display_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared types and constants for the seven-segment display arbiter.
//   digit_t      - one 4-bit display digit code
//   BLANK_DIGIT  - code the display controller renders as an unlit digit
//   arb_state_t  - arbiter state encoding (BLANK used only when the
//                  SSD_ARB_BLANK_EN macro is defined)
//   max_int      - elaboration-time helper for sizing counters
package ssd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        BLANK = 2'd2
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ssd_rr_picker.sv
// ssd_rr_picker
// Combinational round-robin search. Scans req starting at index start and
// wrapping around; the first set bit wins.
// Ports:
//   req    [N_REQ-1:0]          candidate request vector
//   start  [$clog2(N_REQ)-1:0]  first index examined
//   found                       high when any bit of req is set
//   winner [$clog2(N_REQ)-1:0]  index of the first set bit at/after start
module ssd_rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] start,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int OW = $clog2(N_REQ);

    // Walk all N_REQ positions once, beginning at start; only the first hit
    // is recorded so later set bits cannot override it.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(start) + k) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// ssd_display_arbiter
// Shares one DIGITS-wide seven-segment display between N_REQ requesters.
// One owner at a time, chosen round-robin; each owner keeps the display for
// at least HOLD_CYCLES while it keeps requesting. All outputs are registered.
// Optional build macro SSD_ARB_BLANK_EN: every ownership change passes
// through BLANK_CYCLES of blank display with no grant.
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   req         per-requester level request
//   frames_in   packed frames, requester r digit d at [(r*DIGITS+d)*4 +: 4]
//   grant       one-hot current owner, zero when none
//   owner       index of current (or last) owner
//   active      high when grant is non-zero
//   digits_out  digit array for the display controller
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DIGITS       = 8,
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DIGITS*4-1:0] frames_in,
    output logic [N_REQ-1:0]          grant,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      active,
    output digit_t                    digits_out [0:DIGITS-1]
);

    localparam int OW = $clog2(N_REQ);
    // One timer serves both the hold count and the blank gap.
    localparam int TW = $clog2(max_int(HOLD_CYCLES, BLANK_CYCLES));
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
`ifdef SSD_ARB_BLANK_EN
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
`endif

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [TW-1:0]    timer_q, timer_d;
    digit_t           digits_q [0:DIGITS-1];
    digit_t           digits_d [0:DIGITS-1];
`ifdef SSD_ARB_BLANK_EN
    logic [OW-1:0]    pend_q, pend_d;
`endif

    logic             show_frame;
    logic [OW-1:0]    show_idx;
    logic [N_REQ-1:0] pick_req;
    logic [OW-1:0]    pick_start;
    logic             pick_found;
    logic [OW-1:0]    pick_winner;

    // Search always begins just after the current owner, so the owner is
    // considered last. While owning, the owner is masked out so pick_found
    // means "someone else is waiting".
    assign pick_start = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign pick_req   = (state_q == OWN) ? (req & ~(N_REQ'(1) << owner_q)) : req;

    ssd_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (pick_req),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Next-state logic. show_frame/show_idx select which requester's frame
    // is loaded into the digit registers on this edge; otherwise all blank.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        show_frame = 1'b0;
        show_idx   = owner_q;
`ifdef SSD_ARB_BLANK_EN
        pend_d     = pend_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                timer_d = '0;
                if (pick_found) begin
                    state_d    = OWN;
                    owner_d    = pick_winner;
                    grant_d    = N_REQ'(1) << pick_winner;
                    show_frame = 1'b1;
                    show_idx   = pick_winner;
                end
            end
            OWN: begin
                // Release and expiry share one path; expiry only matters when
                // somebody else is waiting.
                if (!req[owner_q] || (timer_q == HOLD_LAST && pick_found)) begin
                    timer_d = '0;
                    if (pick_found) begin
`ifdef SSD_ARB_BLANK_EN
                        state_d = BLANK;
                        grant_d = '0;
                        pend_d  = pick_winner;
`else
                        owner_d    = pick_winner;
                        grant_d    = N_REQ'(1) << pick_winner;
                        show_frame = 1'b1;
                        show_idx   = pick_winner;
`endif
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    if (timer_q != HOLD_LAST) begin
                        timer_d = timer_q + 1'b1;
                    end
                    show_frame = 1'b1;
                    show_idx   = owner_q;
                end
            end
`ifdef SSD_ARB_BLANK_EN
            BLANK: begin
                // owner_q still names the previous owner here, so a
                // re-arbitration on exit starts after it.
                grant_d = '0;
                if (timer_q == BLANK_LAST) begin
                    timer_d = '0;
                    if (req[pend_q]) begin
                        state_d    = OWN;
                        owner_d    = pend_q;
                        grant_d    = N_REQ'(1) << pend_q;
                        show_frame = 1'b1;
                        show_idx   = pend_q;
                    end else if (pick_found) begin
                        state_d    = OWN;
                        owner_d    = pick_winner;
                        grant_d    = N_REQ'(1) << pick_winner;
                        show_frame = 1'b1;
                        show_idx   = pick_winner;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // Digit registers load a whole frame or all-blank, never a mix.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            digits_d[d] = BLANK_DIGIT;
            if (show_frame) begin
                digits_d[d] = frames_in[(int'(show_idx) * DIGITS + d) * 4 +: 4];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= OW'(N_REQ - 1);
            timer_q <= '0;
            for (int d = 0; d < DIGITS; d++) begin
                digits_q[d] <= BLANK_DIGIT;
            end
`ifdef SSD_ARB_BLANK_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            for (int d = 0; d < DIGITS; d++) begin
                digits_q[d] <= digits_d[d];
            end
`ifdef SSD_ARB_BLANK_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign owner      = owner_q;
    assign active     = |grant_q;
    assign digits_out = digits_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// tb_ssd_display_arbiter
// Self-checking bench for ssd_display_arbiter with N_REQ=4, DIGITS=8,
// HOLD_CYCLES=8, BLANK_CYCLES=3. Directed scenarios followed by randomized
// requests, frames and resets, all compared against an ownership model.
// Honors SSD_ARB_BLANK_EN in the same way as the design.
module tb_ssd_display_arbiter;

    localparam int N     = 4;
    localparam int DIG   = 8;
    localparam int HOLD  = 8;
    localparam int BLANK = 3;

    logic             clk;
    logic             resetn;
    logic [N-1:0]     req;
    logic [N*DIG*4-1:0] framesIn;
    logic [N-1:0]     grant;
    logic [1:0]       owner;
    logic             active;
    ssd_pkg::digit_t  digitsOut [0:DIG-1];

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: who owns the display, for how many edges, and
    // whether a blank gap is in progress.
    int          mOwner;
    bit          mActive;
    int          mAge;
    bit          mBlank;
    int          mBlankLeft;
    int          mPend;
    logic [31:0] mShown;

    ssd_display_arbiter #(
        .N_REQ        (N),
        .DIGITS       (DIG),
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .frames_in  (framesIn),
        .grant      (grant),
        .owner      (owner),
        .active     (active),
        .digits_out (digitsOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] frameOf(input logic [N*DIG*4-1:0] f, input int r);
        logic [N*DIG*4-1:0] s;
        s = f >> (r * 32);
        return s[31:0];
    endfunction

    function automatic logic [31:0] packDigits();
        logic [31:0] p;
        for (int d = 0; d < DIG; d++) p[d*4 +: 4] = digitsOut[d];
        return p;
    endfunction

    // First requester after 'from' (wrapping, 'from' itself last) that is
    // requesting and is not 'exclude'; -1 if none.
    function automatic int rrPick(input int from, input logic [N-1:0] r, input int exclude);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (r[i] && i != exclude) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner     = N - 1;
        mActive    = 0;
        mAge       = 0;
        mBlank     = 0;
        mBlankLeft = 0;
        mPend      = 0;
        mShown     = 32'hFFFF_FFFF;
    endtask

    task automatic modelGrant(input int w);
        mOwner  = w;
        mActive = 1;
        mAge    = 0;
    endtask

    task automatic modelSwitch(input int w);
`ifdef SSD_ARB_BLANK_EN
        mActive    = 0;
        mBlank     = 1;
        mBlankLeft = BLANK;
        mPend      = w;
`else
        modelGrant(w);
`endif
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelStep(input logic [N-1:0] r, input logic [N*DIG*4-1:0] f);
        int w;
        if (mBlank) begin
            mBlankLeft--;
            if (mBlankLeft == 0) begin
                mBlank = 0;
                if (r[mPend]) modelGrant(mPend);
                else begin
                    w = rrPick(mOwner, r, -1);
                    if (w >= 0) modelGrant(w);
                end
            end
        end else if (!mActive) begin
            w = rrPick(mOwner, r, -1);
            if (w >= 0) modelGrant(w);
        end else begin
            w = rrPick(mOwner, r, mOwner);
            if (!r[mOwner]) begin
                if (w >= 0) modelSwitch(w);
                else mActive = 0;
            end else if (mAge >= HOLD - 1 && w >= 0) begin
                modelSwitch(w);
            end else begin
                mAge++;
            end
        end
        mShown = mActive ? frameOf(f, mOwner) : 32'hFFFF_FFFF;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkAll();
        logic [N-1:0] expGrant;
        expGrant = mActive ? (N'(1) << mOwner) : '0;
        checkOutput("grant", 32'(grant), 32'(expGrant));
        checkOutput("active", 32'(active), 32'(mActive));
        checkOutput("owner", 32'(owner), 32'(mOwner));
        checkOutput("digits", packDigits(), mShown);
        checkOutput("onehot", 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        modelStep(req, framesIn);
        #1;
        checkAll();
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic doReset();
        #2;
        resetn = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic repeatStimulus(input logic [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) applyStimulus(r);
    endtask

    initial begin
        logic [N-1:0] rnd;
        resetn   = 1'b0;
        req      = '0;
        framesIn = {$urandom, $urandom, $urandom, 32'hFFFF_F123};
        modelReset();
        @(negedge clk);
        checkAll();
        @(negedge clk);
        resetn = 1'b1;

        // Grant requester 0, reset mid-ownership, then re-grant.
        repeatStimulus(4'b0001, 3);
        doReset();
        repeatStimulus(4'b0001, 2);

        // Rotation between two steady requesters.
        repeatStimulus(4'b0000, 2);
        repeatStimulus(4'b1010, 30);

        // Sole requester keeps the display; its frame changes live.
        repeatStimulus(4'b0000, 2);
        for (int i = 0; i < 50; i++) begin
            if (i == 20) framesIn[2*32 +: 32] = 32'h8765_4321;
            applyStimulus(4'b0100);
        end

        // Early release to a waiting requester, then release to idle.
        repeatStimulus(4'b0000, 2);
        repeatStimulus(4'b0001, 4);
        repeatStimulus(4'b0100, 3);
        repeatStimulus(4'b0000, 3);

        // Release exactly at hold expiry.
        repeatStimulus(4'b0001, 8);
        repeatStimulus(4'b0010, 4);

        // Rotation, with the latched winner dropping during any blank gap.
        repeatStimulus(4'b0000, 2);
        repeatStimulus(4'b0011, 10);
        repeatStimulus(4'b1001, 6);

        // Randomized phase.
        rnd = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) rnd = N'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) framesIn = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rnd);
            if ($urandom_range(0, 149) == 0) doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
